// File: rtl/dm_responder.sv
// Data-memory responder for the core's DM port: a word array behind a one-entry
// posted write buffer, with combinational loads, sticky protocol error and saturating counters.
module dm_responder #(
  parameter int DEPTH = 1024,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             DM_enable,
  input  logic             DM_read,
  input  logic             DM_write,
  input  logic [11:0]      DM_address,
  input  logic [31:0]      DM_in,
  output logic [31:0]      DM_out,
  output logic             wb_pending,
  output logic             err,
  output logic [CNT_W-1:0] rd_count,
  output logic [CNT_W-1:0] wr_count
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0]      mem_q [DEPTH];

  logic             wbPending_q, wbPending_d;
  logic [AW-1:0]    wbAddr_q, wbAddr_d;
  logic [31:0]      wbData_q, wbData_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] rdCount_q, rdCount_d;
  logic [CNT_W-1:0] wrCount_q, wrCount_d;

  logic [AW-1:0]    wordIdx;
  logic             reqValid, aligned, inRange;
  logic             legalLoad, legalStore, protoErr, drain;

  assign wordIdx    = DM_address[AW+1:2];
  assign reqValid   = DM_enable & (DM_read ^ DM_write);
  assign aligned    = (DM_address[1:0] == 2'b00);
  assign inRange    = ({1'b0, DM_address[11:2]} < 11'(DEPTH));
  assign legalLoad  = reqValid & aligned & inRange & DM_read;
  assign legalStore = reqValid & aligned & inRange & DM_write;
  assign protoErr   = DM_enable & ((DM_read & DM_write) |
                                   ((DM_read | DM_write) & (~aligned | ~inRange)));
  // The array has a single port that the load path owns, so a load stalls the drain.
  assign drain      = wbPending_q & ~legalLoad;

  always_comb begin
    wbPending_d = wbPending_q;
    wbAddr_d    = wbAddr_q;
    wbData_d    = wbData_q;
    if (legalStore) begin
      wbPending_d = 1'b1;
      wbAddr_d    = wordIdx;
      wbData_d    = DM_in;
    end else if (drain) begin
      wbPending_d = 1'b0;
    end
    err_d     = err_q | protoErr;
    rdCount_d = (legalLoad  && (rdCount_q != '1)) ? rdCount_q + 1'b1 : rdCount_q;
    wrCount_d = (legalStore && (wrCount_q != '1)) ? wrCount_q + 1'b1 : wrCount_q;
  end

  always_comb begin
    DM_out = 32'h0;
    if (legalLoad) begin
      if (wbPending_q && (wbAddr_q == wordIdx)) DM_out = wbData_q;
      else                                      DM_out = mem_q[wordIdx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wbPending_q <= 1'b0;
      wbAddr_q    <= '0;
      wbData_q    <= '0;
      err_q       <= 1'b0;
      rdCount_q   <= '0;
      wrCount_q   <= '0;
    end else begin
      wbPending_q <= wbPending_d;
      wbAddr_q    <= wbAddr_d;
      wbData_q    <= wbData_d;
      err_q       <= err_d;
      rdCount_q   <= rdCount_d;
      wrCount_q   <= wrCount_d;
    end
  end

  // Array contents survive reset; reset only suppresses a drain at the same edge.
  always_ff @(posedge clk) begin
    if (!rst && drain) mem_q[wbAddr_q] <= wbData_q;
  end

  assign wb_pending = wbPending_q;
  assign err        = err_q;
  assign rd_count   = rdCount_q;
  assign wr_count   = wrCount_q;

endmodule

// File: tb/tb_dm_responder.sv
// Scoreboard bench for dm_responder: three instances share one stimulus stream
// (default sizing, 4-bit counters, 256-word array); load data is checked by a monitor.
module tb_dm_responder;

  logic        clk;
  logic        rst;
  logic        dmEnable, dmRead, dmWrite;
  logic [11:0] dmAddress;
  logic [31:0] dmIn;

  logic [31:0] mainOut, cntOut, smallOut;
  logic        mainWb, cntWb, smallWb;
  logic        mainErr, cntErr, smallErr;
  logic [15:0] mainRd, mainWr, smallRd, smallWr;
  logic [3:0]  cntRd, cntWr;

  int checkCount = 0;
  int failCount  = 0;
  int loadIdx    = 0;
  logic [31:0] expectQ [$];

  dm_responder #(.DEPTH(1024), .CNT_W(16)) u_main (
    .clk(clk), .rst(rst), .DM_enable(dmEnable), .DM_read(dmRead), .DM_write(dmWrite),
    .DM_address(dmAddress), .DM_in(dmIn), .DM_out(mainOut), .wb_pending(mainWb),
    .err(mainErr), .rd_count(mainRd), .wr_count(mainWr));

  dm_responder #(.DEPTH(1024), .CNT_W(4)) u_cnt (
    .clk(clk), .rst(rst), .DM_enable(dmEnable), .DM_read(dmRead), .DM_write(dmWrite),
    .DM_address(dmAddress), .DM_in(dmIn), .DM_out(cntOut), .wb_pending(cntWb),
    .err(cntErr), .rd_count(cntRd), .wr_count(cntWr));

  dm_responder #(.DEPTH(256), .CNT_W(16)) u_small (
    .clk(clk), .rst(rst), .DM_enable(dmEnable), .DM_read(dmRead), .DM_write(dmWrite),
    .DM_address(dmAddress), .DM_in(dmIn), .DM_out(smallOut), .wb_pending(smallWb),
    .err(smallErr), .rd_count(smallRd), .wr_count(smallWr));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Drive one cycle of request; loads push their expected data into the scoreboard.
  task automatic applyStimulus(input logic en, input logic rd, input logic wr,
                               input logic [11:0] addr, input logic [31:0] data,
                               input logic [31:0] expLoad);
    dmEnable  = en;
    dmRead    = rd;
    dmWrite   = wr;
    dmAddress = addr;
    dmIn      = data;
    if (en && rd) expectQ.push_back(expLoad);
    @(posedge clk);
    #1;
    dmEnable = 1'b0;
    dmRead   = 1'b0;
    dmWrite  = 1'b0;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 1'b0, 12'h000, 32'h0, 32'h0);
  endtask

  task automatic doReset();
    rst = 1'b1;
    idle();
    rst = 1'b0;
  endtask

  // Monitor: whenever the main instance is presented a load, compare DM_out to the queue head.
  always @(negedge clk) begin
    if (!rst && dmEnable && dmRead) begin
      loadIdx++;
      if (expectQ.size() == 0) begin
        checkCount++;
        failCount++;
        $display("[TB] FAIL load%0d: got 0x%08h, expected no load pending", loadIdx, mainOut);
      end else begin
        checkOutput($sformatf("load%0d_data", loadIdx), mainOut, expectQ.pop_front());
      end
    end
  end

  initial begin
    rst = 1'b0; dmEnable = 1'b0; dmRead = 1'b0; dmWrite = 1'b0; dmAddress = '0; dmIn = '0;
    @(posedge clk); #1;

    // Reset state
    doReset();
    checkOutput("rst_wb",  32'(mainWb),  32'h0);
    checkOutput("rst_err", 32'(mainErr), 32'h0);
    checkOutput("rst_rd",  32'(mainRd),  32'h0);
    checkOutput("rst_wr",  32'(mainWr),  32'h0);

    // Store then forwarded load, then drain and reload from the array
    applyStimulus(1'b1, 1'b0, 1'b1, 12'h010, 32'hDEADBEEF, 32'h0);
    checkOutput("st_wb", 32'(mainWb), 32'h1);
    checkOutput("st_wr", 32'(mainWr), 32'h1);
    applyStimulus(1'b1, 1'b1, 1'b0, 12'h010, 32'h0, 32'hDEADBEEF);
    checkOutput("ld_holds_wb", 32'(mainWb), 32'h1);
    checkOutput("ld_rd", 32'(mainRd), 32'h1);
    idle();
    checkOutput("drain_wb", 32'(mainWb), 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b0, 12'h010, 32'h0, 32'hDEADBEEF);

    // Back-to-back stores with a same-word overwrite
    doReset();
    applyStimulus(1'b1, 1'b0, 1'b1, 12'h000, 32'h1, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b1, 12'h004, 32'h2, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b1, 12'h000, 32'h3, 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b0, 12'h000, 32'h0, 32'h3);
    applyStimulus(1'b1, 1'b1, 1'b0, 12'h004, 32'h0, 32'h2);
    checkOutput("b2b_wr",  32'(mainWr),  32'h3);
    checkOutput("b2b_rd",  32'(mainRd),  32'h2);
    checkOutput("b2b_err", 32'(mainErr), 32'h0);
    checkOutput("b2b_wb",  32'(mainWb),  32'h1);
    idle();

    // Protocol errors
    doReset();
    applyStimulus(1'b1, 1'b1, 1'b0, 12'h013, 32'h0, 32'h0);
    checkOutput("misalign_err", 32'(mainErr), 32'h1);
    checkOutput("misalign_rd",  32'(mainRd),  32'h0);
    applyStimulus(1'b1, 1'b1, 1'b1, 12'h020, 32'h99, 32'h0);
    checkOutput("rdwr_err", 32'(mainErr), 32'h1);
    checkOutput("rdwr_wr",  32'(mainWr),  32'h0);
    checkOutput("rdwr_wb",  32'(mainWb),  32'h0);
    doReset();
    checkOutput("err_cleared", 32'(mainErr), 32'h0);

    // Reset discards a buffered store
    applyStimulus(1'b1, 1'b0, 1'b1, 12'h040, 32'h55, 32'h0);
    idle();
    applyStimulus(1'b1, 1'b0, 1'b1, 12'h040, 32'hAA, 32'h0);
    checkOutput("pre_rst_wb", 32'(mainWb), 32'h1);
    doReset();
    checkOutput("rst_discard_wb", 32'(mainWb), 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b0, 12'h040, 32'h0, 32'h55);

    // Counter saturation on the 4-bit instance
    doReset();
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'b1, 1'b0, 12'h040, 32'h0, 32'h55);
    checkOutput("sat_rd_cnt4",  32'(cntRd),  32'd15);
    checkOutput("sat_rd_cnt16", 32'(mainRd), 32'd20);
    applyStimulus(1'b1, 1'b1, 1'b0, 12'h040, 32'h0, 32'h55);
    checkOutput("sat_hold_cnt4", 32'(cntRd), 32'd15);

    // Out-of-range only for the 256-word instance; disabled store ignored
    doReset();
    applyStimulus(1'b1, 1'b0, 1'b1, 12'h400, 32'h77, 32'h0);
    checkOutput("oor_small_err", 32'(smallErr), 32'h1);
    checkOutput("oor_small_wr",  32'(smallWr),  32'h0);
    checkOutput("oor_small_wb",  32'(smallWb),  32'h0);
    checkOutput("oor_main_err",  32'(mainErr),  32'h0);
    checkOutput("oor_main_wr",   32'(mainWr),   32'h1);
    applyStimulus(1'b0, 1'b0, 1'b1, 12'h000, 32'h12345678, 32'h0);
    checkOutput("dis_small_wr",  32'(smallWr),  32'h0);
    checkOutput("dis_small_err", 32'(smallErr), 32'h1);
    checkOutput("dis_main_wr",   32'(mainWr),   32'h1);
    checkOutput("dis_main_drain", 32'(mainWb),  32'h0);
    dmEnable = 1'b1; dmRead = 1'b1; dmAddress = 12'h400;
    #2;
    checkOutput("oor_small_ld0", smallOut, 32'h0);
    dmEnable = 1'b0; dmRead = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b0, 12'h400, 32'h0, 32'h77);

    idle();
    checkOutput("scoreboard_empty", 32'(expectQ.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
